botao_debounce: RTL

//  Conditions the raw push-button pin ahead of the processor top, which consumes it as 'botao'.

---
 rtl/botao_debounce.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/botao_debounce.sv
// botao_debounce: synchronises a raw push-button pin, filters contact bounce and emits a clean
// level plus one-cycle press/release strobes. Define BOTAO_REPEAT_EN to enable auto-repeat pulses.
module botao_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW_IN   = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_in,
  output logic botao_nivel,
  output logic botao_pulso,
  output logic botao_solto,
  output logic confirmando
);

  localparam int            CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CONT_ONE     = CW'(1);
  localparam logic [CW-1:0] CONT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          PIN_RELEASED = (ACTIVE_LOW_IN != 0);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_p;
  state_t                 r_state;
  logic [CW-1:0]          r_cont;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("botao_debounce: illegal parameter value");
  end

`ifdef BOTAO_REPEAT_EN
  localparam int            RW        = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep_inc;

  assign w_rep_inc = r_rep + RW'(1);
`endif

  // NOTE: the synchroniser resets to the released pin level so a held button is seen as a new press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{PIN_RELEASED}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], botao_in};
    end
  end

  // Polarity-normalised: 1 means pressed.
  assign w_p = r_sync[SYNC_STAGES-1] ^ PIN_RELEASED;

  // NOTE: every state element here uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= SOLTO;
      r_cont      <= '0;
      botao_nivel <= 1'b0;
      botao_pulso <= 1'b0;
      botao_solto <= 1'b0;
      confirmando <= 1'b0;
`ifdef BOTAO_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      botao_pulso <= 1'b0;
      botao_solto <= 1'b0;
      confirmando <= 1'b0;
      case (r_state)
        SOLTO: begin
          if (w_p) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state     <= PRESSIONADO;
              botao_nivel <= 1'b1;
              botao_pulso <= 1'b1;
            end else begin
              r_state     <= CONF_PRESS;
              r_cont      <= CONT_ONE;
              confirmando <= 1'b1;
            end
          end
        end
        CONF_PRESS: begin
          if (!w_p) begin
            r_state <= SOLTO;
            r_cont  <= '0;
          end else if (r_cont == CONT_LAST) begin
            r_state     <= PRESSIONADO;
            r_cont      <= '0;
            botao_nivel <= 1'b1;
            botao_pulso <= 1'b1;
          end else begin
            r_cont      <= r_cont + CW'(1);
            confirmando <= 1'b1;
          end
        end
        PRESSIONADO: begin
          if (!w_p) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state     <= SOLTO;
              botao_nivel <= 1'b0;
              botao_solto <= 1'b1;
`ifdef BOTAO_REPEAT_EN
              r_rep       <= '0;
`endif
            end else begin
              r_state     <= CONF_SOLTA;
              r_cont      <= CONT_ONE;
              confirmando <= 1'b1;
            end
          end else begin
`ifdef BOTAO_REPEAT_EN
            // First repeat after REPEAT_DELAY held cycles, then fold back to keep the period.
            if (w_rep_inc == REP_FIRST) begin
              botao_pulso <= 1'b1;
              r_rep       <= w_rep_inc;
            end else if (w_rep_inc == REP_WRAP) begin
              botao_pulso <= 1'b1;
              r_rep       <= REP_FIRST;
            end else begin
              r_rep <= w_rep_inc;
            end
`endif
          end
        end
        CONF_SOLTA: begin
          if (w_p) begin
            r_state <= PRESSIONADO;
            r_cont  <= '0;
          end else if (r_cont == CONT_LAST) begin
            r_state     <= SOLTO;
            r_cont      <= '0;
            botao_nivel <= 1'b0;
            botao_solto <= 1'b1;
`ifdef BOTAO_REPEAT_EN
            r_rep       <= '0;
`endif
          end else begin
            r_cont      <= r_cont + CW'(1);
            confirmando <= 1'b1;
          end
        end
        default: begin
          r_state <= SOLTO;
          r_cont  <= '0;
        end
      endcase
    end
  end

endmodule
